// File: rtl/filter_weight_loader_pkg.sv
// Shared constants and FSM state encoding for the filter weight loader and its skid register.
package filter_weight_loader_pkg;

  localparam int DEF_WID_FILTER = 16;
  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_NUM_TAPS   = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } fwl_state_e;

  function automatic int cnt_width(input int taps);
    return $clog2(taps + 1);
  endfunction

endpackage

// File: rtl/weight_skid_reg.sv
// One-entry holding register for a weight that returns from memory while downstream is held.
// Load and drain take effect at the next edge; clear wins over load, load wins over drain.
module weight_skid_reg #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_dat_i,
  input  logic         drain_i,
  output logic         vld_o,
  output logic [W-1:0] dat_o
);

  logic         vld_q;
  logic [W-1:0] dat_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else if (clr_i) begin
      vld_q <= 1'b0;
    end else if (load_i) begin
      vld_q <= 1'b1;
      dat_q <= load_dat_i;
    end else if (drain_i) begin
      vld_q <= 1'b0;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/filter_weight_loader.sv
// Streams one NUM_TAPS-weight kernel from weight memory into the filter shift register, last index first.
// Reads start the cycle after start and shifts trail by one cycle; hold stalls both, a returning word parks in the skid.
module filter_weight_loader
  import filter_weight_loader_pkg::*;
#(
  parameter int WID_FILTER = DEF_WID_FILTER,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int NUM_TAPS   = DEF_NUM_TAPS
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_W-1:0]     base_addr_i,
  input  logic                  hold_i,
  output logic                  mem_rd_en_o,
  output logic [ADDR_W-1:0]     mem_rd_addr_o,
  input  logic [WID_FILTER-1:0] mem_rd_data_i,
  output logic                  sr_shift_o,
  output logic [WID_FILTER-1:0] sr_data_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int                CNT_W    = cnt_width(NUM_TAPS);
  localparam logic [CNT_W-1:0]  TAPS_CNT = CNT_W'(NUM_TAPS);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_TAPS - 1);
  localparam logic [ADDR_W-1:0] TOP_OFS  = ADDR_W'(NUM_TAPS - 1);

  fwl_state_e        state_q, state_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  shift_cnt_q, shift_cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              rd_pend_q;

  logic                  skid_vld;
  logic [WID_FILTER-1:0] skid_dat;
  logic                  in_fetch;
  logic                  accept;
  logic                  shift_direct;
  logic                  skid_load;
  logic                  skid_drain;

  always_comb begin
    in_fetch      = (state_q == FETCH);
    accept        = !in_fetch && start_i;
    busy_o        = in_fetch;
    done_o        = (state_q == DONE);
    mem_rd_en_o   = in_fetch && !hold_i && (issue_cnt_q < TAPS_CNT);
    // Highest-index weight first; the subtraction wraps within the address space.
    mem_rd_addr_o = in_fetch ? (base_q + TOP_OFS - ADDR_W'(issue_cnt_q)) : '0;

    shift_direct  = rd_pend_q && !hold_i;
    skid_load     = rd_pend_q && hold_i;
    skid_drain    = skid_vld && !hold_i;
    sr_shift_o    = shift_direct || skid_drain;
    if (shift_direct) begin
      sr_data_o = mem_rd_data_i;
    end else if (skid_drain) begin
      sr_data_o = skid_dat;
    end else begin
      sr_data_o = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    shift_cnt_d = shift_cnt_q;
    base_d      = base_q;
    case (state_q)
      FETCH: begin
        if (mem_rd_en_o) begin
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
        end
        if (sr_shift_o) begin
          shift_cnt_d = shift_cnt_q + CNT_W'(1);
          if (shift_cnt_q == LAST_CNT) begin
            state_d = DONE;
          end
        end
      end
      default: begin
        // IDLE and DONE both accept a new request, giving back-to-back loads.
        if (start_i) begin
          state_d     = FETCH;
          base_d      = base_addr_i;
          issue_cnt_d = '0;
          shift_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      shift_cnt_q <= '0;
      base_q      <= '0;
      rd_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      shift_cnt_q <= shift_cnt_d;
      base_q      <= base_d;
      rd_pend_q   <= mem_rd_en_o;
    end
  end

  weight_skid_reg #(
    .W(WID_FILTER)
  ) u_skid (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (accept),
    .load_i     (skid_load),
    .load_dat_i (mem_rd_data_i),
    .drain_i    (skid_drain),
    .vld_o      (skid_vld),
    .dat_o      (skid_dat)
  );

endmodule

// File: tb/tb_filter_weight_loader.sv
// Directed bench: queue-based reference model checked every cycle plus literal pins per scenario.
module tb_filter_weight_loader;

  localparam int AW = 10;
  localparam int DW = 16;

  typedef int rel9_t [9];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data = 16'hDEAD;
  logic          sr_shift;
  logic [DW-1:0] sr_data;
  logic          busy;
  logic          done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int k_edge = 0;

  filter_weight_loader dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .base_addr_i   (base_addr),
    .hold_i        (hold),
    .mem_rd_en_o   (mem_rd_en),
    .mem_rd_addr_o (mem_rd_addr),
    .mem_rd_data_i (mem_rd_data),
    .sr_shift_o    (sr_shift),
    .sr_data_o     (sr_data),
    .busy_o        (busy),
    .done_o        (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Weight memory: addr n holds n+100, one-cycle read latency; stale cycles return a poison word.
  always @(posedge clk) mem_rd_data <= mem_rd_en ? DW'(32'(mem_rd_addr) + 100) : 16'hDEAD;

  // Convolver filter shift register: new weight enters tap 1.
  logic [DW-1:0] taps [1:9];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i <= 9; i++) taps[i] <= '0;
    end else if (sr_shift) begin
      for (int i = 9; i >= 2; i--) taps[i] <= taps[i-1];
      taps[1] <= sr_data;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: a load is a list of 9 reads, returned words queue up and leave one per unheld cycle.
  int m_state = 0;
  int m_base = 0;
  int m_reads = 0;
  int m_shifts = 0;
  bit m_pend = 1'b0;
  int m_pend_val = 0;
  int m_q [$];
  bit e_busy, e_done, e_en, e_sh;
  int e_addr, e_dat, rel;

  int rd_addr_q [$];
  int rd_rel_q [$];
  int sh_dat_q [$];
  int sh_rel_q [$];
  int done_rel = -1;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_mem_rd_en", mem_rd_en, 0);
      chk("rst_sr_shift", sr_shift, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      m_state = 0;
      m_reads = 0;
      m_shifts = 0;
      m_pend = 1'b0;
      m_q.delete();
    end else begin
      e_busy = (m_state == 1);
      e_done = (m_state == 2);
      e_en   = e_busy && !hold && (m_reads < 9);
      e_addr = (m_base + 8 - m_reads) & 1023;
      if (m_pend) m_q.push_back(m_pend_val);
      e_sh  = !hold && (m_q.size() > 0);
      e_dat = 0;
      if (e_sh) e_dat = m_q.pop_front();

      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("mem_rd_en", mem_rd_en, e_en);
      if (e_en) chk("mem_rd_addr", mem_rd_addr, e_addr);
      chk("sr_shift", sr_shift, e_sh);
      chk("sr_data", sr_data, e_dat);
      chk("rdpend_skid_exclusive", dut.rd_pend_q && dut.skid_vld && !hold, 0);

      rel = cyc - k_edge + 1;
      if (mem_rd_en) begin rd_addr_q.push_back(int'(mem_rd_addr)); rd_rel_q.push_back(rel); end
      if (sr_shift) begin sh_dat_q.push_back(int'(sr_data)); sh_rel_q.push_back(rel); end
      if (done) done_rel = rel;

      m_pend = e_en;
      m_pend_val = e_addr + 100;
      if (e_en) m_reads++;
      if (e_sh) m_shifts++;
      if (m_state == 1) begin
        if (m_shifts == 9) m_state = 2;
      end else if (start) begin
        m_state = 1;
        m_base = int'(base_addr);
        m_reads = 0;
        m_shifts = 0;
      end else begin
        m_state = 0;
      end
    end
  end

  task automatic do_start(input int b);
    start = 1'b1;
    base_addr = AW'(b);
    @(posedge clk); #1;
    start = 1'b0;
    k_edge = cyc;
    rd_addr_q.delete(); rd_rel_q.delete(); sh_dat_q.delete(); sh_rel_q.delete();
    done_rel = -1;
  endtask

  task automatic goto(input int r);
    while (cyc < k_edge + r - 1) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_rel < 0 && n < 40) begin @(posedge clk); #1; n++; end
  endtask

  task automatic chk_load(input string n, input int b, input rel9_t rd_rel, input rel9_t sh_rel);
    chk({n, "_nreads"}, rd_addr_q.size(), 9);
    chk({n, "_nshifts"}, sh_dat_q.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < rd_addr_q.size()) begin
        chk({n, "_rd_addr"}, rd_addr_q[i], (b + 8 - i) & 1023);
        chk({n, "_rd_cycle"}, rd_rel_q[i], rd_rel[i]);
      end
      if (i < sh_dat_q.size()) begin
        chk({n, "_sh_data"}, sh_dat_q[i], ((b + 8 - i) & 1023) + 100);
        chk({n, "_sh_cycle"}, sh_rel_q[i], sh_rel[i]);
      end
    end
  endtask

  task automatic chk_outs_zero(input string n);
    chk({n, "_mem_rd_en"}, mem_rd_en, 0);
    chk({n, "_mem_rd_addr"}, mem_rd_addr, 0);
    chk({n, "_sr_shift"}, sr_shift, 0);
    chk({n, "_sr_data"}, sr_data, 0);
    chk({n, "_busy"}, busy, 0);
    chk({n, "_done"}, done, 0);
  endtask

  rel9_t std_rd = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
  rel9_t std_sh = '{2, 3, 4, 5, 6, 7, 8, 9, 10};
  int wrap_addr [9] = '{4, 3, 2, 1, 0, 1023, 1022, 1021, 1020};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_outs_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic load from base 20.
    do_start(20);
    wait_done();
    chk_load("basic", 20, std_rd, std_sh);
    chk("basic_done_cycle", done_rel, 11);
    chk("basic_tap1", taps[1], 120);
    chk("basic_tap5", taps[5], 124);
    chk("basic_tap9", taps[9], 128);

    // Hold across cycles 4..6.
    do_start(20);
    goto(4); hold = 1'b1;
    goto(7); hold = 1'b0;
    wait_done();
    chk_load("hold_gap", 20, '{1, 2, 3, 7, 8, 9, 10, 11, 12}, '{2, 3, 7, 8, 9, 10, 11, 12, 13});
    chk("hold_gap_done_cycle", done_rel, 14);

    // Hold only on the cycle addr 27 returns: it parks in the skid and shifts next cycle.
    do_start(20);
    goto(3); hold = 1'b1;
    goto(4); hold = 1'b0;
    wait_done();
    chk_load("hold_return", 20, '{1, 2, 4, 5, 6, 7, 8, 9, 10}, '{2, 4, 5, 6, 7, 8, 9, 10, 11});
    chk("hold_return_done_cycle", done_rel, 12);
    chk("hold_return_tap1", taps[1], 120);
    chk("hold_return_tap9", taps[9], 128);

    // Start while busy is ignored; start on the done cycle is accepted.
    do_start(20);
    goto(5);
    start = 1'b1; base_addr = AW'(40);
    @(posedge clk); #1;
    start = 1'b0;
    goto(11);
    chk_load("busy_start", 20, std_rd, std_sh);
    chk("busy_start_done_now", done, 1);
    do_start(40);
    wait_done();
    chk_load("b2b", 40, std_rd, std_sh);
    chk("b2b_first_addr", rd_addr_q.size() > 0 ? rd_addr_q[0] : -1, 48);
    chk("b2b_done_cycle", done_rel, 11);

    // Asynchronous reset mid-load.
    do_start(20);
    goto(6);
    rst = 1'b1;
    #1;
    chk_outs_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("midrst_no_done", done_rel, -1);
    do_start(20);
    wait_done();
    chk_load("after_rst", 20, std_rd, std_sh);
    chk("after_rst_done_cycle", done_rel, 11);

    // Address wrap from base 1020.
    do_start(1020);
    wait_done();
    chk_load("wrap", 1020, std_rd, std_sh);
    for (int i = 0; i < 9; i++) begin
      if (i < rd_addr_q.size()) chk("wrap_addr_literal", rd_addr_q[i], wrap_addr[i]);
    end
    chk("wrap_done_cycle", done_rel, 11);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
